// File: rtl/uart_stego_path.sv
// Steganography datapath between a UART receiver and a UART transmitter.
// Received bytes are assembled little-endian into a frame of PCM samples.
// One message bit replaces the LSB of each sample as the frame completes.
// The modified frame is then sent back out byte by byte under a busy handshake.
//
// Transmit handshake: out_ready is a one-cycle strobe, raised only while
// tx_busy is low, and out_uart_frame is valid in that cycle. The transmitter
// answers by raising tx_busy. The next byte is offered only after tx_busy has
// gone high and then low again. out_uart_frame holds its value between strobes.
module uart_stego_path #(
  parameter int BPS        = 16,
  parameter int FRAME_SIZE = 1
) (
  input  logic                       in_clk,
  input  logic                       in_rst,
  input  logic                       in_uart_ready,
  input  logic [7:0]                 in_uart_frame,
  input  logic [FRAME_SIZE-1:0]      in_message,
  input  logic                       tx_busy,
  output logic [7:0]                 out_uart_frame,
  output logic                       out_ready,
  output logic [FRAME_SIZE*BPS-1:0]  out_frame,
  output logic                       out_frame_ready,
  output logic                       out_overrun
);

  localparam int FW = FRAME_SIZE * BPS;
  localparam int N  = FW / 8;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEND       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } ser_state_t;

  // Assembler / embedder state
  logic [CW-1:0] cnt;
  logic [FW-1:0] asm_buf;
  logic [FW-1:0] full_frame;
  logic [FW-1:0] stego_frame;

  // Serialiser state
  ser_state_t    state, state_n;
  logic [CW-1:0] b, b_n;
  logic [FW-1:0] tx_frame, tx_frame_n;
  logic [7:0]    tx_byte_q, tx_byte_n;
  logic [7:0]    byte_b;
  logic          fire;

  // Merge the incoming byte into the partial frame at slot cnt.
  always_comb begin
    full_frame = asm_buf;
    for (int j = 0; j < N; j++) begin
      if (cnt == CW'(j)) full_frame[8*j +: 8] = in_uart_frame;
    end
  end

  // Replace the LSB of every sample with its message bit.
  always_comb begin
    stego_frame = full_frame;
    for (int k = 0; k < FRAME_SIZE; k++) begin
      stego_frame[k*BPS] = in_message[k];
    end
  end

  // Assembler register: collect bytes and publish the embedded frame on the last one.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      cnt             <= '0;
      asm_buf         <= '0;
      out_frame       <= '0;
      out_frame_ready <= 1'b0;
    end else begin
      out_frame_ready <= 1'b0;
      if (in_uart_ready) begin
        asm_buf <= full_frame;
        if (cnt == CW'(N-1)) begin
          cnt             <= '0;
          out_frame       <= stego_frame;
          out_frame_ready <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Select byte b of the frame being transmitted.
  always_comb begin
    byte_b = '0;
    for (int j = 0; j < N; j++) begin
      if (b == CW'(j)) byte_b = tx_frame[8*j +: 8];
    end
  end

  // Serialiser state register.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state     <= IDLE;
      b         <= '0;
      tx_frame  <= '0;
      tx_byte_q <= '0;
    end else begin
      state     <= state_n;
      b         <= b_n;
      tx_frame  <= tx_frame_n;
      tx_byte_q <= tx_byte_n;
    end
  end

  // Serialiser next-state logic; the send strobe fires straight out of SEND.
  always_comb begin
    state_n    = state;
    b_n        = b;
    tx_frame_n = tx_frame;
    tx_byte_n  = tx_byte_q;
    fire       = 1'b0;
    case (state)
      IDLE: begin
        if (out_frame_ready) begin
          tx_frame_n = out_frame;
          b_n        = '0;
          state_n    = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          fire      = 1'b1;
          tx_byte_n = byte_b;
          state_n   = WAIT_START;
        end
      end
      WAIT_START: begin
        if (tx_busy) state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          b_n     = b + CW'(1);
          state_n = (b == CW'(N-1)) ? IDLE : SEND;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs held at zero while reset is asserted.
  always_comb begin
    out_ready      = fire & ~in_rst;
    out_uart_frame = in_rst ? 8'h00 : (fire ? byte_b : tx_byte_q);
    out_overrun    = out_frame_ready & (state != IDLE) & ~in_rst;
  end

endmodule

// File: tb/tb_uart_stego_path.sv
// Bench for uart_stego_path: a one-sample instance and a two-sample instance,
// each with an auto-responding transmitter model and an output monitor.
module tb_uart_stego_path;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  logic        rst = 1'b1;

  // Instance 1: FRAME_SIZE=1
  logic        rdy1 = 1'b0;
  logic [7:0]  byte1 = 8'h00;
  logic [0:0]  msg1 = 1'b0;
  logic        tx_busy1;
  logic [7:0]  out_byte1;
  logic        out_ready1;
  logic [15:0] out_frame1;
  logic        ofr1;
  logic        ovr1;

  // Instance 2: FRAME_SIZE=2
  logic        rdy2 = 1'b0;
  logic [7:0]  byte2 = 8'h00;
  logic [1:0]  msg2 = 2'b00;
  logic        tx_busy2;
  logic [7:0]  out_byte2;
  logic        out_ready2;
  logic [31:0] out_frame2;
  logic        ofr2;
  logic        ovr2;

  logic tx_force   = 1'b0;
  logic resp_busy1 = 1'b0;
  logic resp_busy2 = 1'b0;
  int   busy_len1  = 3;
  int   busy_len2  = 2;
  assign tx_busy1 = tx_force | resp_busy1;
  assign tx_busy2 = resp_busy2;

  uart_stego_path #(.BPS(16), .FRAME_SIZE(1)) dut1 (
    .in_clk(clk), .in_rst(rst), .in_uart_ready(rdy1), .in_uart_frame(byte1),
    .in_message(msg1), .tx_busy(tx_busy1), .out_uart_frame(out_byte1),
    .out_ready(out_ready1), .out_frame(out_frame1), .out_frame_ready(ofr1),
    .out_overrun(ovr1)
  );

  uart_stego_path #(.BPS(16), .FRAME_SIZE(2)) dut2 (
    .in_clk(clk), .in_rst(rst), .in_uart_ready(rdy2), .in_uart_frame(byte2),
    .in_message(msg2), .tx_busy(tx_busy2), .out_uart_frame(out_byte2),
    .out_ready(out_ready2), .out_frame(out_frame2), .out_frame_ready(ofr2),
    .out_overrun(ovr2)
  );

  // Scoreboard queues
  logic [7:0]  exp_q[$];
  logic [31:0] exp_f_q[$];
  logic [7:0]  got_q[$];
  int          got_cyc[$];
  logic [31:0] frm_q[$];
  logic [7:0]  exp2_q[$];
  logic [31:0] exp2_f_q[$];
  logic [7:0]  got2_q[$];
  logic [31:0] frm2_q[$];
  int ovr_cnt  = 0;
  int ovr2_cnt = 0;
  int wide_cnt = 0;
  logic prev_or1 = 1'b0;
  logic prev_or2 = 1'b0;

  // Transmitter model 1: rise a cycle after each strobe, stay busy busy_len1 cycles.
  initial forever begin
    @(negedge clk); #1;
    if (out_ready1 === 1'b1) begin
      @(negedge clk); resp_busy1 = 1'b1;
      repeat (busy_len1) @(negedge clk);
      resp_busy1 = 1'b0;
    end
  end

  // Transmitter model 2.
  initial forever begin
    @(negedge clk); #1;
    if (out_ready2 === 1'b1) begin
      @(negedge clk); resp_busy2 = 1'b1;
      repeat (busy_len2) @(negedge clk);
      resp_busy2 = 1'b0;
    end
  end

  // Output monitors, sampling mid-cycle.
  initial forever begin
    @(negedge clk); #1;
    if (out_ready1 === 1'b1) begin got_q.push_back(out_byte1); got_cyc.push_back(cyc); end
    if (out_ready1 === 1'b1 && prev_or1) wide_cnt++;
    prev_or1 = (out_ready1 === 1'b1);
    if (ofr1 === 1'b1) frm_q.push_back(32'(out_frame1));
    if (ovr1 === 1'b1) ovr_cnt++;
    if (out_ready2 === 1'b1) got2_q.push_back(out_byte2);
    if (out_ready2 === 1'b1 && prev_or2) wide_cnt++;
    prev_or2 = (out_ready2 === 1'b1);
    if (ofr2 === 1'b1) frm2_q.push_back(out_frame2);
    if (ovr2 === 1'b1) ovr2_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: little-endian byte concatenation, then force each 16-bit
  // sample to be even or odd according to its message bit.
  function automatic logic [63:0] model_frame(input logic [7:0] by[8], input int nb,
                                              input int fs, input logic [7:0] msg);
    logic [63:0] raw;
    logic [63:0] s;
    raw = 64'd0;
    for (int j = 0; j < nb; j++) raw = raw + (64'(by[j]) << (8*j));
    for (int k = 0; k < fs; k++) begin
      s   = (raw >> (16*k)) & 64'hFFFF;
      raw = raw - ((s % 64'd2) << (16*k)) + (64'(msg[k]) << (16*k));
    end
    return raw;
  endfunction

  task automatic send1(input logic [7:0] v, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk); rdy1 = 1'b1; byte1 = v;
    @(negedge clk); rdy1 = 1'b0;
  endtask

  task automatic send2(input logic [7:0] v, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk); rdy2 = 1'b1; byte2 = v;
    @(negedge clk); rdy2 = 1'b0;
  endtask

  task automatic queue_frame1(input logic [7:0] b0, input logic [7:0] b1, input logic m, input bit tx);
    logic [7:0]  by[8];
    logic [63:0] f;
    for (int i = 0; i < 8; i++) by[i] = 8'h00;
    by[0] = b0; by[1] = b1;
    f = model_frame(by, 2, 1, {7'd0, m});
    exp_f_q.push_back(f[31:0]);
    if (tx) begin exp_q.push_back(f[7:0]); exp_q.push_back(f[15:8]); end
  endtask

  task automatic frame1(input logic [7:0] b0, input logic [7:0] b1, input logic m, input int gap);
    queue_frame1(b0, b1, m, 1'b1);
    msg1 = m;
    send1(b0, gap);
    send1(b1, gap);
  endtask

  task automatic frame2(input logic [7:0] b[4], input logic [1:0] m, input int gap);
    logic [7:0]  by[8];
    logic [63:0] f;
    for (int i = 0; i < 8; i++) by[i] = (i < 4) ? b[i] : 8'h00;
    f = model_frame(by, 4, 2, {6'd0, m});
    exp2_f_q.push_back(f[31:0]);
    for (int i = 0; i < 4; i++) exp2_q.push_back(8'(f >> (8*i)));
    msg2 = m;
    for (int i = 0; i < 4; i++) send2(b[i], gap);
  endtask

  task automatic drain1(input string tag);
    int k = 0;
    while (got_q.size() < exp_q.size() && k < 1200) begin @(negedge clk); k++; end
    chk({tag, "_wait"}, 64'(got_q.size() >= exp_q.size()), 64'd1);
    repeat (busy_len1 + 4) @(negedge clk);
    while (exp_q.size() > 0 && got_q.size() > 0)
      chk({tag, "_byte"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    while (exp_f_q.size() > 0 && frm_q.size() > 0)
      chk({tag, "_frame"}, 64'(frm_q.pop_front()), 64'(exp_f_q.pop_front()));
    chk({tag, "_left"}, 64'(got_q.size() + frm_q.size() + exp_q.size() + exp_f_q.size()), 64'd0);
    got_q.delete(); frm_q.delete(); exp_q.delete(); exp_f_q.delete(); got_cyc.delete();
  endtask

  task automatic drain2(input string tag);
    int k = 0;
    while (got2_q.size() < exp2_q.size() && k < 1200) begin @(negedge clk); k++; end
    chk({tag, "_wait"}, 64'(got2_q.size() >= exp2_q.size()), 64'd1);
    repeat (busy_len2 + 4) @(negedge clk);
    while (exp2_q.size() > 0 && got2_q.size() > 0)
      chk({tag, "_byte"}, 64'(got2_q.pop_front()), 64'(exp2_q.pop_front()));
    while (exp2_f_q.size() > 0 && frm2_q.size() > 0)
      chk({tag, "_frame"}, 64'(frm2_q.pop_front()), 64'(exp2_f_q.pop_front()));
    chk({tag, "_left"}, 64'(got2_q.size() + frm2_q.size() + exp2_q.size() + exp2_f_q.size()), 64'd0);
    got2_q.delete(); frm2_q.delete(); exp2_q.delete(); exp2_f_q.delete();
  endtask

  initial begin
    logic [7:0] b4[4];
    int k;
    int base;

    // Reset, with a byte strobe that must be ignored
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rdy1 = 1'b1; byte1 = 8'hAA;
    @(negedge clk); rdy1 = 1'b0;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("reset_out1", {out_byte1, out_ready1, out_frame1, ofr1, ovr1}, 64'd0);
    chk("reset_out2", {out_byte2, out_ready2, out_frame2, ofr2, ovr2}, 64'd0);

    // Directed frames
    frame1(8'h3F, 8'hFF, 1'b1, 0);
    #1; chk("dir1_out_frame", 64'(out_frame1), 64'hFF3F);
    drain1("dir1");
    frame1(8'h01, 8'hF0, 1'b0, 1);
    drain1("dir2");

    // Latency: first strobe exactly two cycles after the last byte
    queue_frame1(8'h3E, 8'h12, 1'b1, 1'b1);
    msg1 = 1'b1;
    send1(8'h3E, 0);
    @(negedge clk); rdy1 = 1'b1; byte1 = 8'h12;
    @(negedge clk); rdy1 = 1'b0; #1;
    chk("lat_frame_ready", 64'(ofr1), 64'd1);
    chk("lat_frame_val", 64'(out_frame1), 64'h123F);
    chk("lat_no_early_strobe", 64'(out_ready1), 64'd0);
    @(negedge clk); #1;
    chk("lat_strobe", 64'(out_ready1), 64'd1);
    chk("lat_byte", 64'(out_byte1), 64'h3F);
    drain1("lat");

    // Partial frame discarded by reset; byte during reset ignored
    send1(8'h3F, 0);
    @(negedge clk); rst = 1'b1; rdy1 = 1'b1; byte1 = 8'h77;
    @(negedge clk); rst = 1'b0; rdy1 = 1'b0; #1;
    chk("rst_mid_out_frame", 64'(out_frame1), 64'd0);
    frame1(8'h01, 8'hF0, 1'b1, 0);
    #1; chk("rst_mid_value", 64'(out_frame1), 64'hF001);
    drain1("rst_mid");

    // Transmitter held busy, then a long busy period
    tx_force = 1'b1; busy_len1 = 870;
    frame1(8'hA5, 8'h5A, 1'b0, 0);
    repeat (40) @(negedge clk); #1;
    chk("busy_hold", 64'(got_q.size()), 64'd0);
    @(negedge clk); tx_force = 1'b0;
    repeat (20) @(negedge clk); #1;
    chk("busy_release_one", 64'(got_q.size()), 64'd1);
    k = 0;
    while (got_q.size() < 2 && k < 1000) begin @(negedge clk); k++; end
    chk("busy_second_wait", 64'(got_q.size() >= 2), 64'd1);
    if (got_cyc.size() >= 2)
      chk("busy_gap", 64'(got_cyc[1] - got_cyc[0] >= 870), 64'd1);
    drain1("busy");
    busy_len1 = 3;

    // Overrun: second frame completes while the first is still in flight
    busy_len1 = 40;
    base = ovr_cnt;
    frame1(8'h10, 8'h20, 1'b1, 0);
    queue_frame1(8'h30, 8'h40, 1'b0, 1'b0);
    msg1 = 1'b0;
    send1(8'h30, 0);
    send1(8'h40, 0);
    drain1("overrun");
    chk("overrun_count", 64'(ovr_cnt - base), 64'd1);
    busy_len1 = 3;

    // Randomized frames on instance 1
    for (int i = 0; i < 20; i++) begin
      busy_len1 = $urandom_range(1, 6);
      frame1(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3));
      drain1("rand1");
    end

    // Two-sample frames on instance 2
    b4[0] = 8'h10; b4[1] = 8'h00; b4[2] = 8'h21; b4[3] = 8'h00;
    frame2(b4, 2'b01, 0);
    #1; chk("fs2_out_frame", 64'(out_frame2), 64'h0020_0011);
    drain2("fs2_dir");
    for (int i = 0; i < 6; i++) begin
      busy_len2 = $urandom_range(1, 5);
      for (int j = 0; j < 4; j++) b4[j] = 8'($urandom);
      frame2(b4, 2'($urandom), $urandom_range(0, 2));
      drain2("fs2_rand");
    end

    chk("strobe_width", 64'(wide_cnt), 64'd0);
    chk("overrun_total1", 64'(ovr_cnt), 64'd1);
    chk("overrun_total2", 64'(ovr2_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_stego_path.md
# uart_stego_path

Byte-stream steganography datapath between a UART receiver and a UART transmitter. Received bytes are assembled into frames of PCM samples, and one message bit replaces the LSB of each sample. The modified frame is then re-serialised as bytes to the transmitter under a busy handshake. The block comprises three stages: assembler (uart2sample), embedder (bit_changer_seq) and serialiser (sample2uart).

## Interface
- BPS, 16: bits per sample; must be a multiple of 8.
- FRAME_SIZE, 1: samples per frame; also the number of message bits per frame.
- in_clk  in  1  system clock; all logic on rising edge.
- in_rst  in  1  reset, synchronous and active-high.
- in_uart_ready  in  1  one-cycle strobe: in_uart_frame holds a received byte.
- in_uart_frame  in  8  received byte.
- in_message  in  FRAME_SIZE  message bits; bit k is embedded into sample k.
- tx_busy  in  1  transmitter active flag.
- out_uart_frame  out  8  byte for the transmitter; held stable between strobes.
- out_ready  out  1  one-cycle strobe: transmit out_uart_frame.
- out_frame  out  FRAME_SIZE*BPS  last modified frame, for observation.
- out_frame_ready  out  1  one-cycle strobe when out_frame updates.
- out_overrun  out  1  one-cycle strobe when a completed frame is dropped.

## Operation
- N = FRAME_SIZE*BPS/8 bytes per frame. Byte order is little-endian: byte j fills frame bits [8j+7:8j].
- **Assembler**
  - On each in_uart_ready, the byte is stored at index cnt, then cnt increments.
  - When byte N-1 is stored, cnt wraps to 0 and the complete frame is passed to the embedder.
  - in_uart_ready is ignored while in_rst=1.
- **Embedder**
  - Sample k is frame[k*BPS +: BPS].
  - Output sample k = {sample_k[BPS-1:1], in_message[k]}.
  - in_message is sampled in the cycle the frame completes.
  - All other bits pass unchanged. No arithmetic; widths are preserved.
- **Serialiser FSM** states: IDLE, SEND, WAIT_START, WAIT_DONE.
  - IDLE: on out_frame_ready, latch out_frame, set byte index b=0, go to SEND.
  - SEND: when tx_busy=0, drive out_uart_frame = byte b, pulse out_ready for one cycle, go to WAIT_START. While tx_busy=1, stay in SEND.
  - WAIT_START: when tx_busy=1, go to WAIT_DONE.
  - WAIT_DONE: when tx_busy=0, increment b. If b was N-1, go to IDLE; otherwise go to SEND.
  - If out_frame_ready arrives while the serialiser is not in IDLE, that frame is not serialised, and out_overrun pulses in the same cycle as out_frame_ready.
  - out_frame still updates when a frame is dropped.
- **Reset**: clears cnt, b, FSM state (to IDLE) and all outputs to 0, including out_frame. A partial frame is discarded; a frame in transmission is abandoned.

## Timing
- in_uart_ready of the last byte in cycle t: out_frame/out_frame_ready valid at cycle t+1 (one register stage; the embedder is folded into that register).
- out_frame_ready at cycle t+1 with the serialiser idle: the FSM enters SEND at t+2. The first out_ready pulses at t+2 if tx_busy=0, so latency from last input byte to first output strobe is 2 cycles.
- Each out_ready is exactly one cycle wide. Consecutive out_ready strobes are separated by one full tx_busy high-then-low cycle.
- tx_busy is expected to rise 1 cycle after out_ready. The serialiser waits in WAIT_START indefinitely; there is no timeout.
- Simultaneous in_rst and in_uart_ready: reset wins and the byte is discarded.
- Simultaneous last byte and non-idle serialiser: the frame is dropped and out_overrun pulses, as in Operation.

## Test plan
- FRAME_SIZE=1, in_message=1; bytes 3F, FF -> out_frame=0xFF3F; out_uart_frame 3F then FF, each with one out_ready.
- in_message=0; bytes 01, F0 -> out_frame=0xF000; transmitted 00, F0.
- in_message=1; bytes 3E, 12 -> out_frame=0x123F; transmitted 3F, 12; first out_ready exactly 2 cycles after the last in_uart_ready.
- Byte 3F, then in_rst pulse, then bytes 01, F0 with in_message=1 -> single frame 0xF001; no frame containing 3F.
- tx_busy forced high throughout -> no out_ready. Release tx_busy -> exactly one out_ready. Model tx_busy high for 870 cycles -> second byte follows only after tx_busy falls.
- Second frame completed while the first is still transmitting -> out_overrun=1 for one cycle; only the first frame's 2 bytes are transmitted.
- FRAME_SIZE=2; bytes 10, 00, 21, 00 with in_message=2'b01 -> out_frame=0x0020_0011; 4 bytes out: 11, 00, 20, 00.
